down_timer: RTL and testbench

Loadable down-counting timer with prescaler, one-shot/periodic modes, pause and abort. It is the count-down counterpart of the free-running up counter. Software-style control pulses load a start value, and the block decrements it every prescaled tick. It flags expiry with a single-cycle pulse, so it can serve as the timeout/interval source next to the up counter in the system design.

---
 rtl/down_timer_pkg.sv | 13 +
 rtl/down_timer_prescaler.sv | 26 ++
 rtl/down_timer.sv | 115 +++++++++++
 tb/tb_down_timer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared state encoding and default widths for the down_timer block.
package down_timer_pkg;

  localparam int N_DEFAULT = 4;
  localparam int P_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer_prescaler.sv
// Tick generator: counts enabled cycles and emits a tick every prescale+1 of them.
module tick_prescaler #(
  parameter int P = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [P-1:0] prescale,
  output logic         tick
);

  logic [P-1:0] cnt;

  assign tick = enable && (cnt == prescale);

  // A disabled prescaler holds its phase so a pause resumes mid-period.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic reload, pause and abort.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int P = P_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         periodic,
  input  logic [N-1:0] load_value,
  input  logic [P-1:0] prescale,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         expired
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] count_d;
  logic [N-1:0] reload_q, reload_d;
  logic [P-1:0] prescale_q, prescale_d;
  logic         periodic_q, periodic_d;
  logic         expired_d;
  logic         psc_clear, psc_enable, tick;

  function automatic logic [N-1:0] dec_sat(input logic [N-1:0] value);
    return (value == '0) ? '0 : value - ONE;
  endfunction

  tick_prescaler #(.P(P)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .clear    (psc_clear),
    .enable   (psc_enable),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    expired_d  = 1'b0;
    psc_clear  = 1'b0;
    psc_enable = 1'b0;

    if (stop) begin
      state_d   = IDLE;
      psc_clear = 1'b1;
    end else if (start) begin
      // A restart discards any tick due this cycle, so a pending expiry is lost.
      psc_clear  = 1'b1;
      periodic_d = periodic;
      prescale_d = prescale;
      if (load_value != '0) begin
        count_d  = load_value;
        reload_d = load_value;
        state_d  = RUN;
      end else begin
        count_d   = '0;
        expired_d = 1'b1;
        state_d   = IDLE;
      end
    end else if (state_q == RUN || state_q == PAUSED) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        state_d    = RUN;
        psc_enable = 1'b1;
        if (tick) begin
          if (count > ONE) begin
            count_d = dec_sat(count);
          end else begin
            expired_d = 1'b1;
            if (periodic_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      busy    <= (state_d != IDLE);
      expired <= expired_d;
    end
  end

  // Start-sampled configuration; only meaningful once a start has been seen.
  always_ff @(posedge clock) begin
    reload_q   <= reload_d;
    prescale_q <= prescale_d;
    periodic_q <= periodic_d;
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed-vector scoreboard bench for down_timer.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset, start, stop, pause, periodic;
  logic [3:0] load_value, prescale;
  logic [3:0] count;
  logic       busy, expired;

  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       expired;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vec_id = 0;

  down_timer #(.N(4), .P(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .periodic   (periodic),
    .load_value (load_value),
    .prescale   (prescale),
    .count      (count),
    .busy       (busy),
    .expired    (expired)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (count !== e.count || busy !== e.busy || expired !== e.expired) begin
        miscompares++;
        $display("FAIL vec%0d: got count=%0d busy=%0b expired=%0b, want count=%0d busy=%0b expired=%0b",
                 vec_id, count, busy, expired, e.count, e.busy, e.expired);
      end
      vec_id++;
    end
  end

  task automatic cyc(input logic rs, input logic st, input logic sp, input logic pa,
                     input logic pe, input logic [3:0] lv, input logic [3:0] ps,
                     input logic [3:0] ec, input logic eb, input logic ee);
    exp_t e;
    reset = rs; start = st; stop = sp; pause = pa;
    periodic = pe; load_value = lv; prescale = ps;
    @(posedge clock);
    #1;
    e.count = ec; e.busy = eb; e.expired = ee;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] ec, input logic eb, input logic ee);
    cyc(0, 0, 0, 0, 0, 4'd0, 4'd0, ec, eb, ee);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0; periodic = 0;
    load_value = 0; prescale = 0;

    // reset held 5 cycles, then released
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);

    // one-shot, load 3, prescale 0
    cyc(0, 1, 0, 0, 0, 4'd3, 4'd0, 4'd3, 1, 0);
    idle(2, 1, 0);
    idle(1, 1, 0);
    idle(0, 0, 1);
    idle(0, 0, 0);

    // periodic, load 2, prescale 1
    cyc(0, 1, 0, 0, 1, 4'd2, 4'd1, 4'd2, 1, 0);
    idle(2, 1, 0);
    idle(1, 1, 0);
    idle(1, 1, 0);
    idle(2, 1, 1);
    idle(2, 1, 0);
    idle(1, 1, 0);
    idle(1, 1, 0);
    idle(2, 1, 1);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd2, 0, 0);
    idle(2, 0, 0);

    // one-shot, load 4, pause 3 cycles once count reaches 2
    cyc(0, 1, 0, 0, 0, 4'd4, 4'd0, 4'd4, 1, 0);
    idle(3, 1, 0);
    idle(2, 1, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd2, 1, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd2, 1, 0);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd2, 1, 0);
    idle(1, 1, 0);
    idle(0, 0, 1);
    idle(0, 0, 0);

    // start with load 0: single expiry, never busy
    cyc(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1);
    idle(0, 0, 0);

    // stop and start together during RUN resolve to stop
    cyc(0, 1, 0, 0, 0, 4'd5, 4'd0, 4'd5, 1, 0);
    idle(4, 1, 0);
    cyc(0, 1, 1, 0, 0, 4'd9, 4'd0, 4'd4, 0, 0);
    idle(4, 0, 0);

    // restart coincident with terminal tick suppresses expiry
    cyc(0, 1, 0, 0, 0, 4'd2, 4'd0, 4'd2, 1, 0);
    idle(1, 1, 0);
    cyc(0, 1, 0, 0, 0, 4'd3, 4'd0, 4'd3, 1, 0);
    idle(2, 1, 0);
    idle(1, 1, 0);
    idle(0, 0, 1);

    // periodic load 1: expiry every cycle, count stays 1
    cyc(0, 1, 0, 0, 1, 4'd1, 4'd0, 4'd1, 1, 0);
    idle(1, 1, 1);
    idle(1, 1, 1);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd1, 0, 0);

    // reset mid-run
    cyc(0, 1, 0, 0, 0, 4'd5, 4'd2, 4'd5, 1, 0);
    idle(5, 1, 0);
    cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
